pipe_if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS CPU. Holds the PC and selects the next PC from the ID-stage redirect inputs. Fetches from an instruction memory with a variable-latency req/ack handshake. Drives if_pc4/if_inst into the IF/ID pipeline register, presenting a NOP bubble whenever no instruction is available.

---
 rtl/pipe_if_stage_pkg.sv | 26 ++
 rtl/pipe_if_stage_inst_buffer.sv | 42 ++++
 rtl/pipe_if_stage.sv | 132 +++++++++++++
 tb/tb_pipe_if_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select
// encodings, reset/bubble constants and the per-cycle update classes.
package pipe_if_stage_pkg;

  // Next-PC select driven by the ID stage
  localparam logic [1:0] PCS_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PCS_BR  = 2'b01;  // branch target (bpc)
  localparam logic [1:0] PCS_JR  = 2'b10;  // register target (rpc)
  localparam logic [1:0] PCS_J   = 2'b11;  // jump target (jpc)

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll $0,$0,0

  // What the stage does this cycle; the four cases are mutually exclusive
  typedef enum logic [1:0] {
    UPD_ADVANCE,  // instruction delivered and accepted: move to npc
    UPD_STALL,    // instruction available but ID stalled: park it in buffer
    UPD_DEFER,    // miss while a redirect arrives: remember the target
    UPD_HOLD      // miss with nothing to record: keep everything
  } upd_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_if_stage_inst_buffer.sv
// One-entry instruction buffer. Holds a fetched word across a load-use
// stall so the memory is never asked for the same word twice.
module if_inst_buffer (
  input  logic        clk,
  input  logic        clrn,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        buf_valid,
  output logic [31:0] buf_inst
);

  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q,  buf_inst_d;

  // Capture wins over clear; the two are never requested together anyway
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_inst_d  = din;
    end else if (clear) begin
      buf_valid_d = 1'b0;
    end
  end

  // Buffer state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      buf_valid_q <= 1'b0;
      buf_inst_q  <= 32'h0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign buf_valid = buf_valid_q;
  assign buf_inst  = buf_inst_q;

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, deferred-redirect latch, next-PC
// mux and the req/ack fetch interface. A NOP bubble is presented whenever
// no instruction word is available this cycle.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = pipe_if_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = pipe_if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_bubble
);
  import pipe_if_stage_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        buf_valid;
  logic [31:0] buf_inst;
  logic        buf_capture, buf_clear;

  logic        fetch_ok;
  logic [31:0] cur_inst;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] npc;
  upd_e        upd;

  if_inst_buffer u_buf (
    .clk       (clk),
    .clrn      (clrn),
    .capture   (buf_capture),
    .clear     (buf_clear),
    .din       (cur_inst),
    .buf_valid (buf_valid),
    .buf_inst  (buf_inst)
  );

  // Instruction availability and the word presented to IF/ID. An ack that
  // arrives while the buffer is full is a protocol error and is masked by
  // preferring the buffered word.
  always_comb begin
    fetch_ok = buf_valid | imem_ack;
    cur_inst = buf_valid ? buf_inst : imem_rdata;
    pc_plus4 = pc_q + 32'd4;
  end

  // Redirect decode and next-PC priority: an already captured target beats
  // anything new, so the first redirect seen during a miss wins.
  always_comb begin
    redirect = 1'b0;
    target   = 32'h0;
    unique case (pcsource)
      PCS_SEQ: begin redirect = 1'b0; target = 32'h0; end
      PCS_BR:  begin redirect = 1'b1; target = bpc;   end
      PCS_JR:  begin redirect = 1'b1; target = rpc;   end
      PCS_J:   begin redirect = 1'b1; target = jpc;   end
    endcase
    if (pend_valid_q)  npc = pend_target_q;
    else if (redirect) npc = target;
    else               npc = pc_plus4;
    npc = word_align(npc);
  end

  // Classify the cycle; pcsource only counts when ID lets the PC advance
  always_comb begin
    if (fetch_ok && wpcir)                          upd = UPD_ADVANCE;
    else if (fetch_ok)                              upd = UPD_STALL;
    else if (wpcir && redirect && !pend_valid_q)    upd = UPD_DEFER;
    else                                            upd = UPD_HOLD;
  end

  // Next-state for PC, redirect latch and buffer controls
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    buf_capture   = 1'b0;
    buf_clear     = 1'b0;
    unique case (upd)
      UPD_ADVANCE: begin
        pc_d         = npc;
        pend_valid_d = 1'b0;
        buf_clear    = 1'b1;
      end
      UPD_STALL: begin
        // Re-captures the same word when already buffered; harmless
        buf_capture = 1'b1;
      end
      UPD_DEFER: begin
        // Delay-slot fetch keeps going at pc; target is used once it lands
        pend_valid_d  = 1'b1;
        pend_target_d = target;
      end
      UPD_HOLD: begin
        pc_d = pc_q;
      end
    endcase
  end

  // PC and deferred-redirect registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign imem_req  = !buf_valid;
  assign imem_addr = word_align(pc_q);
  assign if_pc4    = pc_plus4;
  assign if_inst   = fetch_ok ? cur_inst : NOP_INST;
  assign if_bubble = !fetch_ok;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed, table-driven bench for the fetch stage. Each row drives one
// cycle of ID/memory inputs and lists the outputs expected in that cycle.
module tb_pipe_if_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_bubble;

  int checks = 0;
  int errors = 0;

  pipe_if_stage dut (
    .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .rpc(rpc),
    .jpc(jpc), .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc4(if_pc4),
    .if_inst(if_inst), .if_bubble(if_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pcs;
    logic [31:0] b, r, j;
    logic        wp, ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr, e_pc4, e_inst;
    logic        e_bub;
  } vec_t;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  // Distinct word per address so a wrong address or stale word shows up
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h2108_5A5A;
  endfunction

  function automatic vec_t mk(input logic [1:0] pcs, input logic [31:0] b,
                              input logic [31:0] r, input logic [31:0] j,
                              input logic wp, input logic ack,
                              input logic [31:0] rd, input logic e_req,
                              input logic [31:0] e_addr, input logic [31:0] e_pc4,
                              input logic [31:0] e_inst, input logic e_bub);
    vec_t v;
    v.pcs = pcs; v.b = b; v.r = r; v.j = j; v.wp = wp; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc4 = e_pc4;
    v.e_inst = e_inst; v.e_bub = e_bub;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req,
                            input logic [31:0] e_addr, input logic [31:0] e_pc4,
                            input logic [31:0] e_inst, input logic e_bub);
    check({tag, " req"},    {31'd0, imem_req},  {31'd0, e_req});
    check({tag, " addr"},   imem_addr,          e_addr);
    check({tag, " pc4"},    if_pc4,             e_pc4);
    check({tag, " inst"},   if_inst,            e_inst);
    check({tag, " bubble"}, {31'd0, if_bubble}, {31'd0, e_bub});
  endtask

  vec_t vecs[22];

  initial begin
    // pcs b r j wp ack rdata | req addr pc4 inst bub
    vecs[0]  = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h0),  1, 32'h0,  32'h4,  inst_of(32'h0),  0);
    vecs[1]  = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h4),  1, 32'h4,  32'h8,  inst_of(32'h4),  0);
    // ack together with a stall: word captured, then re-presented from buffer
    vecs[2]  = mk(2'b00, 0, 0, 0, 0, 1, inst_of(32'h8),  1, 32'h8,  32'hC,  inst_of(32'h8),  0);
    // stray ack with junk while buffered must be ignored
    vecs[3]  = mk(2'b00, 0, 0, 0, 0, 1, JUNK,            0, 32'h8,  32'hC,  inst_of(32'h8),  0);
    vecs[4]  = mk(2'b00, 0, 0, 0, 1, 0, JUNK,            0, 32'h8,  32'hC,  inst_of(32'h8),  0);
    vecs[5]  = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'hC),  1, 32'hC,  32'h10, inst_of(32'hC),  0);
    // 3-cycle ack latency at 0x10
    vecs[6]  = mk(2'b00, 0, 0, 0, 1, 0, JUNK,            1, 32'h10, 32'h14, NOP,             1);
    vecs[7]  = mk(2'b00, 0, 0, 0, 1, 0, JUNK,            1, 32'h10, 32'h14, NOP,             1);
    vecs[8]  = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h10), 1, 32'h10, 32'h14, inst_of(32'h10), 0);
    vecs[9]  = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h14), 1, 32'h14, 32'h18, inst_of(32'h14), 0);
    vecs[10] = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h18), 1, 32'h18, 32'h1C, inst_of(32'h18), 0);
    vecs[11] = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h1C), 1, 32'h1C, 32'h20, inst_of(32'h1C), 0);
    // branch to 0x100 while delay slot 0x20 is delivered
    vecs[12] = mk(2'b01, 32'h100, 32'h500, 32'h600, 1, 1, inst_of(32'h20), 1, 32'h20, 32'h24, inst_of(32'h20), 0);
    vecs[13] = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h100), 1, 32'h100, 32'h104, inst_of(32'h100), 0);
    // jr to unaligned 0x43: low bits forced to 00
    vecs[14] = mk(2'b10, 32'h700, 32'h43, 32'h800, 1, 1, inst_of(32'h104), 1, 32'h104, 32'h108, inst_of(32'h104), 0);
    // jump during a miss at 0x40, second redirect ignored, pending target used
    vecs[15] = mk(2'b11, 32'h900, 32'hA00, 32'h200, 1, 0, JUNK, 1, 32'h40, 32'h44, NOP, 1);
    vecs[16] = mk(2'b01, 32'h300, 32'hB00, 32'hC00, 1, 0, JUNK, 1, 32'h40, 32'h44, NOP, 1);
    vecs[17] = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'h40), 1, 32'h40, 32'h44, inst_of(32'h40), 0);
    // jump to the top word; pc+4 wraps to 0
    vecs[18] = mk(2'b11, 32'h0, 32'h0, 32'hFFFF_FFFC, 1, 1, inst_of(32'h200), 1, 32'h200, 32'h204, inst_of(32'h200), 0);
    vecs[19] = mk(2'b00, 0, 0, 0, 1, 1, inst_of(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 32'h0, inst_of(32'hFFFF_FFFC), 0);
    vecs[20] = mk(2'b01, 32'h30, 32'h0, 32'h0, 1, 1, inst_of(32'h0), 1, 32'h0, 32'h4, inst_of(32'h0), 0);
    // start a miss at 0x30 (reset follows)
    vecs[21] = mk(2'b00, 0, 0, 0, 1, 0, JUNK, 1, 32'h30, 32'h34, NOP, 1);

    clrn = 1'b0; pcsource = 2'b00; bpc = '0; rpc = '0; jpc = '0;
    wpcir = 1'b1; imem_ack = 1'b0; imem_rdata = JUNK;

    @(negedge clk);
    check_outs("reset", 1'b1, 32'h0, 32'h4, NOP, 1'b1);
    clrn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      pcsource = vecs[i].pcs; bpc = vecs[i].b; rpc = vecs[i].r; jpc = vecs[i].j;
      wpcir = vecs[i].wp; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rd;
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_pc4, vecs[i].e_inst, vecs[i].e_bub);
      @(posedge clk);
      @(negedge clk);
    end

    // Still missing at 0x30: confirm, then assert reset between edges
    pcsource = 2'b00; wpcir = 1'b1; imem_ack = 1'b0; imem_rdata = JUNK;
    #1;
    check_outs("miss30", 1'b1, 32'h30, 32'h34, NOP, 1'b1);
    #1;
    clrn = 1'b0;
    #1;
    check_outs("async_rst", 1'b1, 32'h0, 32'h4, NOP, 1'b1);
    @(negedge clk);
    clrn = 1'b1;
    imem_ack = 1'b1; imem_rdata = inst_of(32'h0);
    #1;
    check_outs("restart0", 1'b1, 32'h0, 32'h4, inst_of(32'h0), 1'b0);
    @(posedge clk);
    @(negedge clk);
    imem_rdata = inst_of(32'h4);
    #1;
    check_outs("restart4", 1'b1, 32'h4, 32'h8, inst_of(32'h4), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
